// File: rtl/acondicionador_botones.sv
// Button conditioning ahead of controlVGA: 2-flop sync + debounce on five inputs, press pulses for Up/Down.
// Optional auto-repeat on Up/Down is enabled by defining AUTOREPEAT_EN.
`timescale 1ns/1ps
module acondicionador_botones #(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_BITS   = 20,
  parameter int REP_DELAY  = 12500000,
  parameter int REP_RATE   = 2500000,
  parameter int REP_BITS   = 24
) (
  input  logic Clk,
  input  logic reset,
  input  logic BtnUp,
  input  logic BtnDown,
  input  logic BtnTono,
  input  logic BtnColor,
  input  logic BtnLp,
  output logic Up,
  output logic Down,
  output logic Tono,
  output logic color,
  output logic Lp
);

  localparam int NCH = 5;
  localparam logic [DEB_BITS-1:0] DEB_LAST = DEB_BITS'(DEB_CYCLES - 1);

  // Channel order: 0 Up, 1 Down, 2 Tono, 3 color, 4 Lp.
  logic [NCH-1:0] raw;
  logic [NCH-1:0] s1_reg;
  logic [NCH-1:0] s2_reg;
  logic [NCH-1:0] stable;

  assign raw = {BtnLp, BtnColor, BtnTono, BtnDown, BtnUp};

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= raw;
      s2_reg <= s1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_deb
      logic [DEB_BITS-1:0] cnt_reg;
      logic [DEB_BITS-1:0] cnt_next;
      logic                stable_reg;
      logic                stable_next;

      // Any sample that agrees with the accepted level restarts the count.
      always_comb begin
        cnt_next    = '0;
        stable_next = stable_reg;
        if (s2_reg[gi] != stable_reg) begin
          if (cnt_reg == DEB_LAST) begin
            stable_next = s2_reg[gi];
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
          cnt_reg    <= '0;
          stable_reg <= 1'b0;
        end else begin
          cnt_reg    <= cnt_next;
          stable_reg <= stable_next;
        end
      end

      assign stable[gi] = stable_reg;
    end
  endgenerate

  assign Tono  = stable[2];
  assign color = stable[3];
  assign Lp    = stable[4];

  logic [1:0] stable_d_reg;
  logic [1:0] rise;
  logic       both_rise;
  logic       both_held;
  logic [1:0] rep_pulse;
  logic       up_reg;
  logic       up_next;
  logic       down_reg;
  logic       down_next;

  assign rise      = stable[1:0] & ~stable_d_reg;
  assign both_rise = rise[0] & rise[1];
  assign both_held = stable[0] & stable[1];

`ifdef AUTOREPEAT_EN
  localparam logic [REP_BITS-1:0] REP_DELAY_LAST = REP_BITS'(REP_DELAY - 1);
  localparam logic [REP_BITS-1:0] REP_RATE_LAST  = REP_BITS'(REP_RATE - 1);

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rep
      logic [REP_BITS-1:0] rep_cnt_reg;
      logic [REP_BITS-1:0] rep_cnt_next;
      logic [REP_BITS-1:0] rep_last;
      logic                first_reg;
      logic                first_next;
      logic                pulse;

      // Counts from the initial press pulse; first target is the hold delay, then the rate.
      always_comb begin
        rep_last     = first_reg ? REP_DELAY_LAST : REP_RATE_LAST;
        rep_cnt_next = '0;
        first_next   = 1'b1;
        pulse        = 1'b0;
        if (stable[gi] && !both_held && !rise[gi]) begin
          if (rep_cnt_reg == rep_last) begin
            pulse      = 1'b1;
            first_next = 1'b0;
          end else begin
            rep_cnt_next = rep_cnt_reg + 1'b1;
            first_next   = first_reg;
          end
        end
      end

      always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
          rep_cnt_reg <= '0;
          first_reg   <= 1'b1;
        end else begin
          rep_cnt_reg <= rep_cnt_next;
          first_reg   <= first_next;
        end
      end

      assign rep_pulse[gi] = pulse;
    end
  endgenerate
`else
  // Repeat disabled: constant zero for every legal parameter set, no repeat hardware.
  assign rep_pulse = {2{(REP_DELAY < 1) && (REP_RATE < 1) && (REP_BITS < 1)}};
`endif

  always_comb begin
    up_next   = (rise[0] & ~both_rise) | rep_pulse[0];
    down_next = (rise[1] & ~both_rise) | rep_pulse[1];
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      stable_d_reg <= '0;
      up_reg       <= 1'b0;
      down_reg     <= 1'b0;
    end else begin
      stable_d_reg <= stable[1:0];
      up_reg       <= up_next;
      down_reg     <= down_next;
    end
  end

  assign Up   = up_reg;
  assign Down = down_reg;

endmodule
